// File: rtl/fetch_pair_queue.sv
// Fetch stage: issues one paired instruction-memory read per accepted predictor
// guess and queues the returned PC/instruction pairs for decode.
module fetch_pair_queue #(
    parameter int ADDR_WIDTH  = 32,
    parameter int INSTR_WIDTH = 32,
    parameter int DEPTH       = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic [ADDR_WIDTH-1:0]  pc_in [2],
    input  logic                   pc_valid_in [2],
    input  logic                   pred_branch_in [2],
    output logic                   fetch_stall,
    output logic                   imem_req,
    output logic [ADDR_WIDTH-1:0]  imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_rdata [2],
    output logic                   out_valid [2],
    output logic [ADDR_WIDTH-1:0]  out_pc [2],
    output logic [INSTR_WIDTH-1:0] out_instr [2],
    output logic                   out_pred_branch [2],
    input  logic                   out_ready
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic             inflight_q, inflight_d;

    logic [ADDR_WIDTH-1:0] infl_pc_q [2];
    logic                  infl_valid_q [2];
    logic                  infl_br_q [2];

    logic accept;
    logic push;
    logic pop;
    logic empty;

    // Credits cover both queued entries and the one read still in flight.
    assign fetch_stall = (count_q + {{(CNT_W-1){1'b0}}, inflight_q}) >= CNT_W'(DEPTH);
    assign accept      = ~reset & ~flush & ~fetch_stall & (pc_valid_in[0] | pc_valid_in[1]);
    assign imem_req    = accept;
    assign imem_addr   = accept ? pc_in[0] : '0;

    assign empty = (count_q == '0);
    assign push  = inflight_q & ~flush;
    assign pop   = out_valid[0] & out_ready & ~flush;

    always_comb begin
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        inflight_d = inflight_q;
        if (flush) begin
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            inflight_d = 1'b0;
        end else begin
            inflight_d = accept;
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            inflight_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            inflight_q <= inflight_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_slot
            logic [ADDR_WIDTH-1:0]  pc_mem_q    [DEPTH];
            logic [INSTR_WIDTH-1:0] instr_mem_q [DEPTH];
            logic                   valid_mem_q [DEPTH];
            logic                   br_mem_q    [DEPTH];
            logic                   push_valid;

            // A predicted-taken branch in slot 0 ends the pair.
            if (gi == 0) begin : g_head
                assign push_valid = infl_valid_q[0];
            end else begin : g_tail
                assign push_valid = infl_valid_q[1] & ~infl_br_q[0];
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    infl_pc_q[gi]    <= '0;
                    infl_valid_q[gi] <= 1'b0;
                    infl_br_q[gi]    <= 1'b0;
                end else if (accept) begin
                    infl_pc_q[gi]    <= pc_in[gi];
                    infl_valid_q[gi] <= pc_valid_in[gi];
                    infl_br_q[gi]    <= pred_branch_in[gi];
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        pc_mem_q[i]    <= '0;
                        instr_mem_q[i] <= '0;
                        valid_mem_q[i] <= 1'b0;
                        br_mem_q[i]    <= 1'b0;
                    end
                end else if (push) begin
                    pc_mem_q[wr_ptr_q]    <= infl_pc_q[gi];
                    instr_mem_q[wr_ptr_q] <= imem_rdata[gi];
                    valid_mem_q[wr_ptr_q] <= push_valid;
                    br_mem_q[wr_ptr_q]    <= infl_br_q[gi];
                end
            end

            assign out_valid[gi]       = ~empty & valid_mem_q[rd_ptr_q];
            assign out_pc[gi]          = empty ? '0 : pc_mem_q[rd_ptr_q];
            assign out_instr[gi]       = empty ? '0 : instr_mem_q[rd_ptr_q];
            assign out_pred_branch[gi] = ~empty & br_mem_q[rd_ptr_q];
        end
    endgenerate
endmodule
